// File: rtl/ntt_op_ctrl.sv
// Operation controller for the 8-BFU polynomial multiplier: decodes conf, sequences
// NTT/INTT/pointwise passes and reports completion on done_flag. Optional macro: INTT_SCALE_EN.
module ntt_op_ctrl #(
  parameter int unsigned LOG_N    = 10,
  parameter int unsigned PIPE_LAT = 6,
  parameter int unsigned TW_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        conf,
  output logic [2:0]        done_flag,
  output logic              busy,
  output logic              rd_en,
  output logic [LOG_N-5:0]  rd_addr,
  output logic              wr_en,
  output logic [LOG_N-5:0]  wr_addr,
  output logic [3:0]        stage,
  output logic [TW_W-1:0]   tw_addr,
  output logic [1:0]        bfu_mode
);

  localparam int unsigned ROW_W    = LOG_N - 4;
  localparam int unsigned TW_DEPTH = LOG_N << ROW_W;
  localparam int unsigned DCNT_W   = $clog2(PIPE_LAT + 1);

  localparam logic [ROW_W-1:0]  ROW_LAST     = '1;
  localparam logic [TW_W-1:0]   TW_INTT_INIT = TW_W'(TW_DEPTH - 1);
  localparam logic [3:0]        NTT_LAST     = 4'(LOG_N - 1);
`ifdef INTT_SCALE_EN
  localparam logic [3:0]        INTT_LAST    = 4'(LOG_N);
`else
  localparam logic [3:0]        INTT_LAST    = 4'(LOG_N - 1);
`endif
  localparam logic [DCNT_W-1:0] DRAIN_NEXT   = DCNT_W'(PIPE_LAT - 1);
  localparam logic [DCNT_W-1:0] DRAIN_DONE   = DCNT_W'(PIPE_LAT);

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_NTT_A = 3'd1;
  localparam logic [2:0] OP_PW    = 3'd3;
  localparam logic [2:0] OP_NTT_B = 3'd4;
  localparam logic [2:0] OP_INTT  = 3'd5;

  localparam logic [1:0] MODE_CT    = 2'd0;
  localparam logic [1:0] MODE_GS    = 2'd1;
  localparam logic [1:0] MODE_PW    = 2'd2;
  localparam logic [1:0] MODE_SCALE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_last_conf;
  logic [2:0]          r_op;
  logic [ROW_W-1:0]    r_cnt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [3:0]          r_last_stage;
  logic [TW_W-1:0]     r_tw_next;

  logic [2:0]          r_done_flag;
  logic                r_busy;
  logic                r_rd_en;
  logic [ROW_W-1:0]    r_rd_addr;
  logic [3:0]          r_stage;
  logic [TW_W-1:0]     r_tw_addr;
  logic [1:0]          r_bfu_mode;

  logic [PIPE_LAT-1:0]            r_wr_en_sr;
  logic [PIPE_LAT-1:0][ROW_W-1:0] r_wr_addr_sr;

  logic                w_legal;
  logic                w_accept;
  logic                w_stage_last;
  logic [1:0]          w_acc_mode;
  logic [3:0]          w_acc_last;
  logic [TW_W-1:0]     w_acc_tw;

  // Opcode decode for the command being accepted
  always_comb begin
    w_legal    = 1'b0;
    w_acc_mode = MODE_CT;
    w_acc_last = NTT_LAST;
    w_acc_tw   = '0;
    case (conf)
      OP_NTT_A, OP_NTT_B: begin
        w_legal = 1'b1;
      end
      OP_PW: begin
        w_legal    = 1'b1;
        w_acc_mode = MODE_PW;
        w_acc_last = 4'd0;
      end
      OP_INTT: begin
        w_legal    = 1'b1;
        w_acc_mode = MODE_GS;
        w_acc_last = INTT_LAST;
        w_acc_tw   = TW_INTT_INIT;
      end
      default: ;
    endcase
  end

  assign w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                        (conf != r_last_conf) && w_legal;
  assign w_stage_last = (r_stage == r_last_stage);

  // Command FSM and registered datapath controls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_conf  <= OP_IDLE;
      r_op         <= OP_IDLE;
      r_cnt        <= '0;
      r_dcnt       <= '0;
      r_last_stage <= '0;
      r_tw_next    <= '0;
      r_done_flag  <= '0;
      r_busy       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_stage      <= '0;
      r_tw_addr    <= '0;
      r_bfu_mode   <= MODE_CT;
    end else begin
      r_last_conf <= conf;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state      <= S_RUN;
            r_op         <= conf;
            r_done_flag  <= '0;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_dcnt       <= '0;
            r_stage      <= '0;
            r_last_stage <= w_acc_last;
            r_bfu_mode   <= w_acc_mode;
            r_tw_addr    <= w_acc_tw;
            r_tw_next    <= w_acc_tw;
          end else if ((r_state == S_DONE) && (conf == OP_IDLE)) begin
            r_state     <= S_IDLE;
            r_done_flag <= '0;
          end
        end
        S_RUN: begin
          r_rd_en   <= 1'b1;
          r_rd_addr <= r_cnt;
          r_cnt     <= r_cnt + 1'b1;
          // Twiddles are stored in access order; pointwise and scale passes hold the address
          if (r_bfu_mode == MODE_CT) begin
            r_tw_addr <= r_tw_next;
            r_tw_next <= r_tw_next + 1'b1;
          end else if (r_bfu_mode == MODE_GS) begin
            r_tw_addr <= r_tw_next;
            if (r_tw_next != '0) r_tw_next <= r_tw_next - 1'b1;
          end
          if (r_cnt == ROW_LAST) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          r_rd_en <= 1'b0;
          r_dcnt  <= r_dcnt + 1'b1;
          // Last stage waits one extra cycle so done_flag follows the final write
          if (!w_stage_last && (r_dcnt == DRAIN_NEXT)) begin
            r_state <= S_RUN;
            r_stage <= r_stage + 4'd1;
            r_cnt   <= '0;
`ifdef INTT_SCALE_EN
            if ((r_op == OP_INTT) && ((r_stage + 4'd1) == 4'(LOG_N))) r_bfu_mode <= MODE_SCALE;
`endif
          end else if (w_stage_last && (r_dcnt == DRAIN_DONE)) begin
            r_state     <= S_DONE;
            r_done_flag <= r_op;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write strobe/row are the read strobe/row delayed by the BFU latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en_sr   <= '0;
      r_wr_addr_sr <= '0;
    end else begin
      r_wr_en_sr[0]   <= r_rd_en;
      r_wr_addr_sr[0] <= r_rd_addr;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        r_wr_en_sr[i]   <= r_wr_en_sr[i-1];
        r_wr_addr_sr[i] <= r_wr_addr_sr[i-1];
      end
    end
  end

  assign done_flag = r_done_flag;
  assign busy      = r_busy;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign wr_en     = r_wr_en_sr[PIPE_LAT-1];
  assign wr_addr   = r_wr_addr_sr[PIPE_LAT-1];
  assign stage     = r_stage;
  assign tw_addr   = r_tw_addr;
  assign bfu_mode  = r_bfu_mode;

endmodule
